// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: default widths, sequential
// increment, reset fetch address and the sequencer state encoding.
package fetch_sequencer_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_PC_INC = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // DROP means the outstanding fetch is stale and its data will be thrown away
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetchState_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Next-PC / instruction-fetch sequencer: issues req/ack reads to instruction
// memory, holds one fetched word for decode and applies branch redirects.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_INC = DEF_PC_INC,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              decode_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc_next
);

   fetchState_e       state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pcNext_q, pcNext_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instrPc_q, instrPc_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] pendingTarget_q, pendingTarget_d;
   logic [ADDR_W-1:0] seqPc;

   // Sequential successor wraps silently at the top of the address space
   assign seqPc = addr_q + ADDR_W'(PC_INC);

   // Next-state and datapath decisions; redirect always wins over sequential flow
   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      addr_d          = addr_q;
      pcNext_d        = pcNext_q;
      instr_d         = instr_q;
      instrPc_d       = instrPc_q;
      valid_d         = valid_q;
      pendingTarget_d = pendingTarget_q;

      case (state_q)
         IDLE: begin
            req_d   = 1'b1;
            state_d = WAIT;
            if (redirect) begin
               addr_d   = redirect_target;
               pcNext_d = redirect_target;
            end else begin
               addr_d   = pcNext_q;
            end
         end

         WAIT: begin
            if (imem_ack) begin
               if (redirect) begin
                  addr_d   = redirect_target;
                  pcNext_d = redirect_target;
               end else begin
                  instr_d   = imem_rdata;
                  instrPc_d = addr_q;
                  valid_d   = 1'b1;
                  req_d     = 1'b0;
                  pcNext_d  = seqPc;
                  state_d   = HOLD;
               end
            end else if (redirect) begin
               pendingTarget_d = redirect_target;
               state_d         = DROP;
            end
         end

         // The old request must still complete before the new target is issued
         DROP: begin
            if (imem_ack) begin
               addr_d   = redirect ? redirect_target : pendingTarget_q;
               pcNext_d = redirect ? redirect_target : pendingTarget_q;
               state_d  = WAIT;
            end else if (redirect) begin
               pendingTarget_d = redirect_target;
            end
         end

         HOLD: begin
            if (redirect) begin
               valid_d  = 1'b0;
               addr_d   = redirect_target;
               pcNext_d = redirect_target;
               req_d    = 1'b1;
               state_d  = WAIT;
            end else if (decode_ready) begin
               valid_d  = 1'b0;
               addr_d   = pcNext_q;
               req_d    = 1'b1;
               state_d  = WAIT;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         req_q           <= 1'b0;
         addr_q          <= RESET_PC;
         pcNext_q        <= RESET_PC;
         instr_q         <= '0;
         instrPc_q       <= '0;
         valid_q         <= 1'b0;
         pendingTarget_q <= '0;
      end else begin
         state_q         <= state_d;
         req_q           <= req_d;
         addr_q          <= addr_d;
         pcNext_q        <= pcNext_d;
         instr_q         <= instr_d;
         instrPc_q       <= instrPc_d;
         valid_q         <= valid_d;
         pendingTarget_q <= pendingTarget_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign pc_next     = pcNext_q;
   assign instr       = instr_q;
   assign instr_pc    = instrPc_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level reference model
// predicts fetch addresses and delivered instructions; a monitor checks them.
module tb_fetch_sequencer;

   localparam int PH_START = 0;
   localparam int PH_FETCH = 1;
   localparam int PH_HOLD  = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic [31:0] nextPc;
   } instrExp_t;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        decode_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic [31:0] pc_next;

   logic        wReq;
   logic [31:0] wAddr;
   logic [31:0] wInstr;
   logic [31:0] wInstrPc;
   logic        wValid;
   logic [31:0] wPcNext;

   int numCompared = 0;
   int numMismatched = 0;

   logic [31:0] reqQ[$];
   instrExp_t   instrQ[$];

   int          mPhase = PH_START;
   logic [31:0] mFetchAddr = 32'h0;
   logic [31:0] mNextPc = 32'h0;
   logic [31:0] mTarget = 32'h0;
   logic        mStale = 1'b0;

   logic        monEnable = 1'b0;
   logic        prevReq = 1'b0;
   logic        prevValid = 1'b0;
   logic        ackTaken = 1'b0;
   logic [31:0] curAddr = 32'h0;
   instrExp_t   curInstr;

   fetch_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .decode_ready    (decode_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .pc_next         (pc_next)
   );

   // Second instance starting at the last word so the first fetch wraps pc_next
   fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) wrapDut (
      .clk             (clk),
      .reset           (reset),
      .redirect        (1'b0),
      .redirect_target (32'h0),
      .imem_req        (wReq),
      .imem_addr       (wAddr),
      .imem_ack        (1'b1),
      .imem_rdata      (32'hA5A5_A5A5),
      .decode_ready    (1'b0),
      .instr           (wInstr),
      .instr_pc        (wInstrPc),
      .instr_valid     (wValid),
      .pc_next         (wPcNext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Reference model: whole-transaction rules, stepped once per clock edge
   task automatic modelStep(input logic rst, input logic redir, input logic [31:0] tgt,
                            input logic ack, input logic [31:0] rdata, input logic dready);
      instrExp_t e;
      if (rst) begin
         mPhase     = PH_START;
         mFetchAddr = 32'h0;
         mNextPc    = 32'h0;
         mStale     = 1'b0;
         reqQ.delete();
         instrQ.delete();
         return;
      end
      case (mPhase)
         PH_START: begin
            if (redir) mFetchAddr = tgt;
            mStale = 1'b0;
            mPhase = PH_FETCH;
            reqQ.push_back(mFetchAddr);
         end
         PH_FETCH: begin
            if (ack) begin
               if (mStale || redir) begin
                  mFetchAddr = redir ? tgt : mTarget;
                  mStale     = 1'b0;
                  reqQ.push_back(mFetchAddr);
               end else begin
                  mNextPc  = mFetchAddr + 32'd4;
                  e.pc     = mFetchAddr;
                  e.data   = rdata;
                  e.nextPc = mNextPc;
                  instrQ.push_back(e);
                  mPhase = PH_HOLD;
               end
            end else if (redir) begin
               mStale  = 1'b1;
               mTarget = tgt;
            end
         end
         default: begin
            if (redir || dready) begin
               mFetchAddr = redir ? tgt : mNextPc;
               reqQ.push_back(mFetchAddr);
               mPhase = PH_FETCH;
            end
         end
      endcase
   endtask

   task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] rdata, input logic dready);
      @(negedge clk);
      reset           = rst;
      redirect        = redir;
      redirect_target = tgt;
      imem_ack        = ack;
      imem_rdata      = rdata;
      decode_ready    = dready;
      @(posedge clk);
      modelStep(rst, redir, tgt, ack, rdata, dready);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req"}, imem_req, 32'd0);
      checkOutput({tag, "_addr"}, imem_addr, 32'h0);
      checkOutput({tag, "_pc_next"}, pc_next, 32'h0);
      checkOutput({tag, "_instr"}, instr, 32'h0);
      checkOutput({tag, "_instr_pc"}, instr_pc, 32'h0);
      checkOutput({tag, "_valid"}, instr_valid, 32'd0);
   endtask

   always @(posedge clk) ackTaken <= imem_ack && imem_req;

   // Monitor: compares DUT-presented transactions against the scoreboard queues
   always @(negedge clk) begin
      if (monEnable) begin
         checkOutput("req_phase", imem_req, (mPhase == PH_FETCH));
         checkOutput("valid_phase", instr_valid, (mPhase == PH_HOLD));
         if (imem_req && (!prevReq || ackTaken)) begin
            if (reqQ.size() == 0) begin
               numCompared++;
               numMismatched++;
               $display("[TB] FAIL req_unexpected: actual=%h expected=none", imem_addr);
            end else begin
               curAddr = reqQ.pop_front();
               checkOutput("req_addr", imem_addr, curAddr);
               checkOutput("req_pc_next", pc_next, curAddr);
            end
         end else if (imem_req) begin
            checkOutput("addr_stable", imem_addr, curAddr);
         end
         if (instr_valid && !prevValid) begin
            if (instrQ.size() == 0) begin
               numCompared++;
               numMismatched++;
               $display("[TB] FAIL instr_unexpected: actual=%h expected=none", instr_pc);
            end else begin
               curInstr = instrQ.pop_front();
               checkOutput("instr_data", instr, curInstr.data);
               checkOutput("instr_pc", instr_pc, curInstr.pc);
               checkOutput("instr_pc_next", pc_next, curInstr.nextPc);
            end
         end else if (instr_valid) begin
            checkOutput("instr_stable", instr, curInstr.data);
            checkOutput("instr_pc_stable", instr_pc, curInstr.pc);
         end
         prevReq   = imem_req;
         prevValid = instr_valid;
      end
   end

   initial begin
      logic        rRst, rRedir, rAck, rReady;
      logic [31:0] rTgt;
      reset = 1'b1;
      redirect = 1'b0;
      redirect_target = 32'h0;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      decode_ready = 1'b0;

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      monEnable = 1'b1;
      checkResetValues("reset");

      // Back-to-back fetches with same-cycle ack and decode always ready
      applyStimulus(0, 0, 0, 1, 32'h1111_1111, 1);
      applyStimulus(0, 0, 0, 1, 32'h1111_1111, 1);
      checkOutput("t1_instr", instr, 32'h1111_1111);
      checkOutput("t1_instr_pc", instr_pc, 32'h0);
      checkOutput("t1_pc_next", pc_next, 32'h4);
      repeat (6) applyStimulus(0, 0, 0, 1, 32'h1111_1111, 1);

      // Delayed ack, then a long decode stall
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t2_addr_held", imem_addr, 32'h0);
      applyStimulus(0, 0, 0, 1, 32'h2222_2222, 0);
      checkOutput("t2_valid", instr_valid, 32'd1);
      repeat (10) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t3_next_addr", imem_addr, 32'h4);
      checkOutput("t3_next_req", imem_req, 32'd1);

      // Two redirects while the fetch is outstanding; the latest target wins
      applyStimulus(0, 1, 32'h40, 0, 0, 0);
      applyStimulus(0, 1, 32'h80, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      checkOutput("t4_addr", imem_addr, 32'h80);
      checkOutput("t4_pc_next", pc_next, 32'h80);
      checkOutput("t4_valid", instr_valid, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'h3333_3333, 0);

      // Redirect beats decode_ready in HOLD
      applyStimulus(0, 1, 32'h100, 0, 0, 1);
      checkOutput("t5_valid", instr_valid, 32'd0);
      checkOutput("t5_addr", imem_addr, 32'h100);

      applyStimulus(1, 0, 0, 0, 0, 0);
      checkResetValues("t6_reset_in_wait");

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t7_wrap_pc_next", wPcNext, 32'h0);
      checkOutput("t7_wrap_instr_pc", wInstrPc, 32'hFFFF_FFFC);
      checkOutput("t7_wrap_instr", wInstr, 32'hA5A5_A5A5);
      checkOutput("t7_wrap_valid", wValid, 32'd1);
      checkOutput("t7_wrap_req", wReq, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         rRst   = ($urandom_range(0, 199) == 0);
         rRedir = ($urandom_range(0, 7) == 0);
         rTgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         if (mPhase == PH_FETCH) rAck = ($urandom_range(0, 2) == 0);
         else rAck = ($urandom_range(0, 9) == 0);
         rReady = $urandom_range(0, 1) == 1;
         applyStimulus(rRst, rRedir, rTgt, rAck, $urandom, rReady);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      checkOutput("req_queue_drained", reqQ.size(), 32'd0);
      checkOutput("instr_queue_drained", instrQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
